seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider_cond_subtractor.sv | 29 ++
 rtl/seq_divider.sv | 103 ++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths and FSM encoding for the sequential divider
package seq_divider_pkg;

  localparam int N_DEF  = 3;
  localparam int W2_DEF = 2 * N_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between a divider client and the divider
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
);

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );

endinterface

// File: rtl/seq_divider_cond_subtractor.sv
// rtl/seq_divider_cond_subtractor.sv - ripple a + ~b + 1 subtractor with no-borrow flag
module cond_subtractor #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-2:0] diff_o,
  output logic         no_borrow_o
);

  logic [W:0]   carry;
  logic [W-1:0] b_inv;

  assign b_inv    = ~b_i;
  assign carry[0] = 1'b1;

  // Only the low W-1 difference bits are produced: when no borrow occurs the
  // result is below the divisor and its top bit is always zero.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign carry[i+1] = (a_i[i] & b_inv[i]) | (a_i[i] & carry[i]) | (b_inv[i] & carry[i]);
  end

  for (genvar i = 0; i < W - 1; i++) begin : g_sum
    assign diff_o[i] = a_i[i] ^ b_inv[i] ^ carry[i];
  end

  assign no_borrow_o = carry[W];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int W2 = 2 * N;
  localparam int CW = $clog2(W2);
  localparam logic [CW-1:0] CNT_LAST = CW'(W2 - 1);

  state_e          state_q;
  logic            busy_q, done_q, dbz_q;
  logic [W2-1:0]   quo_q;
  logic [N-1:0]    rem_q;
  logic [N-1:0]    p_q;
  logic [W2-1:0]   q_q;
  logic [N-1:0]    div_q;
  logic [CW-1:0]   cnt_q;

  logic [N:0]      p_shift;
  logic [N-1:0]    p_diff;
  logic            q_bit;
  logic [N-1:0]    p_d;
  logic [W2-1:0]   q_d;

  // P' brings in the next dividend bit; the stored P never exceeds N bits
  // because a restored remainder is always below the divisor.
  assign p_shift = {p_q, q_q[W2-1]};

  cond_subtractor #(.W(N + 1)) u_sub (
    .a_i         (p_shift),
    .b_i         ({1'b0, div_q}),
    .diff_o      (p_diff),
    .no_borrow_o (q_bit)
  );

  assign p_d = q_bit ? p_diff : p_shift[N-1:0];
  assign q_d = {q_q[W2-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          p_q <= p_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= q_d;
            rem_q   <= p_d;
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          if (bus.start) begin
            div_q <= bus.divisor;
            if (bus.divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= '0;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              p_q     <= '0;
              q_q     <= bus.dividend;
              cnt_q   <= CNT_LAST;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and exhaustive self-checking bench for seq_divider (N=3)
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   done_cnt;
  int   overlap_cnt;
  int   unstable_cnt;
  logic rst_edge;
  logic [5:0] prev_q;
  logic [2:0] prev_r;
  logic       prev_dbz;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap_cnt++;
    if (rst_edge !== 1'b1 && bus.done !== 1'b1 &&
        (bus.quotient !== prev_q || bus.remainder !== prev_r || bus.dbz !== prev_dbz))
      unstable_cnt++;
    prev_q   = bus.quotient;
    prev_r   = bus.remainder;
    prev_dbz = bus.dbz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; lat=1 at that point.
  task automatic wait_done(output int lat, output int saw_busy);
    lat = 1;
    saw_busy = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) saw_busy = 1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] dd, input logic [2:0] dv,
                        input logic [5:0] eq, input logic [2:0] er, input logic ed);
    int lat;
    int saw_busy;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, saw_busy);
    chk({tag, "_lat"}, lat, ed ? 1 : 7);
    chk({tag, "_quot"}, bus.quotient, eq);
    chk({tag, "_rem"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.dbz, ed);
    chk({tag, "_busy_seen"}, saw_busy, ed ? 0 : 1);
  endtask

  initial begin
    int lat;
    int saw_busy;
    int done_before;
    compared     = 0;
    mismatched   = 0;
    done_cnt     = 0;
    overlap_cnt  = 0;
    unstable_cnt = 0;
    prev_q       = '0;
    prev_r       = '0;
    prev_dbz     = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quot", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    run_op("d45_5", 6'd45, 3'd5, 6'd9, 3'd0, 1'b0);
    @(negedge clk);
    run_op("d50_7", 6'd50, 3'd7, 6'd7, 3'd1, 1'b0);

    // Back-to-back: start held through RUN (ignored) and DONE (accepted).
    @(negedge clk);
    bus.dividend = 6'd50;
    bus.divisor  = 3'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.dividend = 6'd63;
    bus.divisor  = 3'd1;
    wait_done(lat, saw_busy);
    chk("b2b1_lat", lat, 7);
    chk("b2b1_quot", bus.quotient, 7);
    chk("b2b1_rem", bus.remainder, 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b2_busy", bus.busy, 1);
    chk("b2b2_done", bus.done, 0);
    wait_done(lat, saw_busy);
    chk("b2b2_lat", lat, 7);
    chk("b2b2_quot", bus.quotient, 63);
    chk("b2b2_rem", bus.remainder, 0);
    chk("b2b2_dbz", bus.dbz, 0);

    @(negedge clk);
    run_op("d7_0", 6'd7, 3'd0, 6'd63, 3'd0, 1'b1);
    @(negedge clk);
    chk("dbz_held", bus.dbz, 1);
    chk("dbz_quot_held", bus.quotient, 63);
    run_op("d0_3", 6'd0, 3'd3, 6'd0, 3'd0, 1'b0);
    @(negedge clk);
    run_op("d5_7", 6'd5, 3'd7, 6'd0, 3'd5, 1'b0);

    // A start pulse during RUN must not disturb the running operation.
    @(negedge clk);
    bus.dividend = 6'd36;
    bus.divisor  = 3'd6;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.dividend = 6'd20;
    bus.divisor  = 3'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, saw_busy);
    chk("ign_lat", lat, 5);
    chk("ign_quot", bus.quotient, 6);
    chk("ign_rem", bus.remainder, 0);
    @(negedge clk);
    chk("ign_idle_done", bus.done, 0);
    chk("ign_idle_busy", bus.busy, 0);

    // Reset in cycle 3 of a run aborts it without a done.
    bus.dividend = 6'd45;
    bus.divisor  = 3'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    done_before = done_cnt;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quot", bus.quotient, 0);
    chk("abort_rem", bus.remainder, 0);
    chk("abort_dbz", bus.dbz, 0);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - done_before, 0);

    for (int dd = 0; dd < 64; dd++) begin
      for (int dv = 1; dv < 8; dv++) begin
        bus.dividend = 6'(dd);
        bus.divisor  = 3'(dv);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, saw_busy);
        chk("exh_identity", 32'(bus.quotient) * 32'(dv) + 32'(bus.remainder), 32'(dd));
        chk("exh_rem_lt_div", (32'(bus.remainder) < 32'(dv)) ? 1 : 0, 1);
        @(negedge clk);
      end
    end

    chk("busy_done_overlap", overlap_cnt, 0);
    chk("outputs_stable", unstable_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
